// File: rtl/pcie4_cfg_msix_requester.sv
// MSI-X requester for the PCIe4 cfg interrupt port: latches per-vector requests, issues them round-robin, retries failures.
// Optional MSIX_REQ_STATS_EN adds saturating sent/fail counters with a synchronous clear.
module pcie4_cfg_msix_requester #(
   parameter int unsigned C_NUM_VECTORS = 8,
   parameter int unsigned C_FUNCTION    = 0,
   parameter int unsigned C_TIMEOUT     = 255,
   parameter int unsigned C_MAX_RETRY   = 3
) (
   input  logic                             aclk,
   input  logic                             areset,
`ifdef MSIX_REQ_STATS_EN
   input  logic                             stat_clr,
   output logic [31:0]                      stat_sent,
   output logic [31:0]                      stat_fail,
`endif
   input  logic [C_NUM_VECTORS-1:0]         irq_req,
   output logic [C_NUM_VECTORS-1:0]         irq_done,
   output logic [C_NUM_VECTORS-1:0]         irq_err,
   input  logic                             tbl_we,
   input  logic [$clog2(C_NUM_VECTORS)-1:0] tbl_idx,
   input  logic [63:0]                      tbl_addr,
   input  logic [31:0]                      tbl_data,
   input  logic [3:0]                       msix_enable,
   input  logic [3:0]                       msix_mask,
   output logic [63:0]                      msix_address,
   output logic [31:0]                      msix_data,
   output logic                             msix_int,
   input  logic                             msix_sent,
   input  logic                             msix_fail,
   output logic [7:0]                       msix_function_number,
   output logic [1:0]                       msix_vec_pending,
   output logic [2:0]                       msix_attr,
   output logic                             msix_tph_present,
   output logic [1:0]                       msix_tph_type,
   output logic [7:0]                       msix_tph_st_tag
);

   localparam int unsigned N  = C_NUM_VECTORS;
   localparam int unsigned IW = $clog2(C_NUM_VECTORS);
   localparam int unsigned TW = 16;
   localparam int unsigned RW = 8;
   localparam int unsigned BW = 4;

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_FAILED, S_BACKOFF, S_RETRY
   } state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    pend_q;
   logic [IW-1:0]   idx_q, rr_q;
   logic [TW-1:0]   timer_q;
   logic [RW-1:0]   retry_q;
   logic [BW-1:0]   bo_q;
   logic [63:0]     addr_q;
   logic [31:0]     data_q;
   logic            int_q;
   logic [N-1:0]    done_q, err_q;
   logic [63:0]     tbl_addr_q [N];
   logic [31:0]     tbl_data_q [N];

   logic            en_ok_c, found_c;
   logic [IW-1:0]   sel_c, cand_c;
   logic [N-1:0]    idx_oh_c, clr_c;
   logic            grant_c, reload_c, issue_c, wait_c, sent_c, fail_c, retry_c, drop_c, backoff_c;

   assign en_ok_c  = msix_enable[2'(C_FUNCTION)] & ~msix_mask[2'(C_FUNCTION)];
   assign idx_oh_c = N'(1) << idx_q;
   assign clr_c    = (sent_c || drop_c) ? idx_oh_c : '0;

   // Round-robin search starting one past the last granted vector
   always_comb begin
      found_c = 1'b0;
      sel_c   = '0;
      cand_c  = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         cand_c = IW'(32'(rr_q) + k);
         if (!found_c && pend_q[cand_c]) begin
            found_c = 1'b1;
            sel_c   = cand_c;
         end
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (en_ok_c && found_c) state_d = S_ISSUE;
         S_ISSUE:   state_d = S_WAIT;
         S_WAIT: begin
            if (msix_sent)                                  state_d = S_IDLE;
            else if (msix_fail || timer_q <= TW'(1))        state_d = S_FAILED;
         end
         S_FAILED:  state_d = (retry_q < RW'(C_MAX_RETRY)) ? S_BACKOFF : S_IDLE;
         S_BACKOFF: if (bo_q == '0) state_d = S_RETRY;
         S_RETRY:   if (en_ok_c && pend_q[idx_q]) state_d = S_ISSUE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Per-state control strobes for the datapath
   always_comb begin
      grant_c   = 1'b0;
      reload_c  = 1'b0;
      issue_c   = 1'b0;
      wait_c    = 1'b0;
      sent_c    = 1'b0;
      fail_c    = 1'b0;
      retry_c   = 1'b0;
      drop_c    = 1'b0;
      backoff_c = 1'b0;
      unique case (state_q)
         S_IDLE:    grant_c = en_ok_c && found_c;
         S_ISSUE:   issue_c = 1'b1;
         S_WAIT: begin
            wait_c = 1'b1;
            sent_c = msix_sent;
            fail_c = !msix_sent && (msix_fail || timer_q <= TW'(1));
         end
         S_FAILED: begin
            if (retry_q < RW'(C_MAX_RETRY)) retry_c = 1'b1;
            else                            drop_c  = 1'b1;
         end
         S_BACKOFF: backoff_c = 1'b1;
         S_RETRY:   reload_c  = en_ok_c && pend_q[idx_q];
         default:   ;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         tbl_addr_q <= '{default: '0};
         tbl_data_q <= '{default: '0};
      end else if (tbl_we) begin
         tbl_addr_q[tbl_idx] <= tbl_addr;
         tbl_data_q[tbl_idx] <= tbl_data;
      end
   end

   // Message payload is captured at grant/re-issue and held through the response
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         pend_q  <= '0;
         idx_q   <= '0;
         rr_q    <= '0;
         timer_q <= '0;
         retry_q <= '0;
         bo_q    <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         int_q   <= 1'b0;
         done_q  <= '0;
         err_q   <= '0;
      end else begin
         pend_q <= (pend_q & ~clr_c) | irq_req;
         int_q  <= (state_d == S_ISSUE);
         done_q <= sent_c ? idx_oh_c : '0;
         err_q  <= drop_c ? idx_oh_c : '0;
         if (grant_c) begin
            idx_q  <= sel_c;
            rr_q   <= sel_c;
            addr_q <= tbl_addr_q[sel_c];
            data_q <= tbl_data_q[sel_c];
         end else if (reload_c) begin
            addr_q <= tbl_addr_q[idx_q];
            data_q <= tbl_data_q[idx_q];
         end
         if (issue_c)                     timer_q <= TW'(C_TIMEOUT);
         else if (wait_c && timer_q != '0) timer_q <= timer_q - TW'(1);
         if (retry_c)                     retry_q <= retry_q + RW'(1);
         else if (sent_c || drop_c)       retry_q <= '0;
         if (retry_c)                     bo_q <= BW'(15);
         else if (backoff_c && bo_q != '0) bo_q <= bo_q - BW'(1);
      end
   end

`ifdef MSIX_REQ_STATS_EN
   logic [31:0] stat_sent_q, stat_fail_q;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         stat_sent_q <= '0;
         stat_fail_q <= '0;
      end else if (stat_clr) begin
         stat_sent_q <= '0;
         stat_fail_q <= '0;
      end else begin
         if (sent_c && stat_sent_q != '1) stat_sent_q <= stat_sent_q + 32'd1;
         if (fail_c && stat_fail_q != '1) stat_fail_q <= stat_fail_q + 32'd1;
      end
   end

   assign stat_sent = stat_sent_q;
   assign stat_fail = stat_fail_q;
`endif

   assign irq_done             = done_q;
   assign irq_err              = err_q;
   assign msix_address         = addr_q;
   assign msix_data            = data_q;
   assign msix_int             = int_q;
   assign msix_function_number = 8'(C_FUNCTION);
   assign msix_vec_pending     = '0;
   assign msix_attr            = '0;
   assign msix_tph_present     = 1'b0;
   assign msix_tph_type        = '0;
   assign msix_tph_st_tag      = '0;

endmodule

// File: tb/tb_pcie4_cfg_msix_requester.sv
// Self-checking bench for pcie4_cfg_msix_requester: vector table, directed corner sequences, randomized traffic vs model.
module tb_pcie4_cfg_msix_requester;

   localparam int unsigned NV = 8;
   localparam int unsigned TO = 10;
   localparam int unsigned MR = 3;

   logic        aclk = 1'b0;
   logic        areset;
   logic [7:0]  irq_req, irq_done, irq_err;
   logic        tbl_we;
   logic [2:0]  tbl_idx;
   logic [63:0] tbl_addr;
   logic [31:0] tbl_data;
   logic [3:0]  msix_enable, msix_mask;
   logic [63:0] msix_address;
   logic [31:0] msix_data;
   logic        msix_int, msix_sent, msix_fail;
   logic [7:0]  msix_function_number;
   logic [1:0]  msix_vec_pending;
   logic [2:0]  msix_attr;
   logic        msix_tph_present;
   logic [1:0]  msix_tph_type;
   logic [7:0]  msix_tph_st_tag;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   always #5 aclk = ~aclk;

   pcie4_cfg_msix_requester #(
      .C_NUM_VECTORS(NV), .C_FUNCTION(0), .C_TIMEOUT(TO), .C_MAX_RETRY(MR)
   ) dut (
      .aclk(aclk), .areset(areset),
      .irq_req(irq_req), .irq_done(irq_done), .irq_err(irq_err),
      .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
      .msix_enable(msix_enable), .msix_mask(msix_mask),
      .msix_address(msix_address), .msix_data(msix_data), .msix_int(msix_int),
      .msix_sent(msix_sent), .msix_fail(msix_fail),
      .msix_function_number(msix_function_number), .msix_vec_pending(msix_vec_pending),
      .msix_attr(msix_attr), .msix_tph_present(msix_tph_present),
      .msix_tph_type(msix_tph_type), .msix_tph_st_tag(msix_tph_st_tag)
   );

   typedef struct {
      int          vec;
      logic [63:0] addr;
      logic [31:0] data;
      int          dly;
      int          exp_lat;
      logic [7:0]  exp_done;
   } vrec_t;

   task automatic tick();
      @(posedge aclk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_int(input int max, output int lat);
      lat = -1;
      for (int i = 1; i <= max && lat < 0; i++) begin
         tick();
         if (msix_int === 1'b1) lat = i;
      end
   endtask

   function automatic logic [63:0] va(input int i);
      return {32'h0000_0001, 32'hFEE0_0000 + 32'(i) * 32'h10};
   endfunction

   function automatic logic [31:0] vd(input int i);
      return 32'hC0DE_0000 + 32'(i);
   endfunction

   // Reference arbitration: first pending index after the last grant, wrapping
   function automatic int arb(input logic [7:0] p, input int last);
      int j;
      for (int k = 1; k <= 8; k++) begin
         j = (last + k) % 8;
         if (p[j]) return j;
      end
      return 0;
   endfunction

   task automatic write_entry(input int i, input logic [63:0] a, input logic [31:0] d);
      tbl_we = 1'b1; tbl_idx = 3'(i); tbl_addr = a; tbl_data = d;
      tick();
      tbl_we = 1'b0;
   endtask

   task automatic do_reset();
      areset = 1'b1; irq_req = '0; msix_sent = 1'b0; msix_fail = 1'b0; tbl_we = 1'b0;
      msix_enable = 4'b0001; msix_mask = 4'b1110;
      repeat (2) tick();
      areset = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) write_entry(i, va(i), vd(i));
   endtask

   // From the msix_int cycle: answer after dly cycles, return positioned one cycle after the answer
   task automatic respond(input bit ok, input int dly);
      repeat (dly) tick();
      if (ok) msix_sent = 1'b1; else msix_fail = 1'b1;
      tick();
      msix_sent = 1'b0; msix_fail = 1'b0;
   endtask

   task automatic pulse(input logic [7:0] v);
      irq_req = v;
      tick();
      irq_req = '0;
   endtask

   vrec_t       tv [4];
   int          lat, cnt, v, dv, last, sent_at, done_at;
   logic [7:0]  pend, pend_p, req_l, clr_l;
   bit          busy, busy_l, exp_int;

   initial begin
      #200_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tv[0] = '{3, 64'h0000_0001_FEE0_0000, 32'h0000_00A5, 5, 2, 8'h08};
      tv[1] = '{0, 64'h0000_0000_1234_5670, 32'hDEAD_0001, 1, 2, 8'h01};
      tv[2] = '{7, 64'hFFFF_FFFF_FFFF_FFF0, 32'hFFFF_FFFF, 3, 2, 8'h80};
      tv[3] = '{5, 64'h0000_00AB_CDEF_0010, 32'h5A5A_5A5A, 10, 2, 8'h20};

      // Reset values
      areset = 1'b1; irq_req = '0; msix_sent = 1'b0; msix_fail = 1'b0; tbl_we = 1'b0;
      tbl_idx = '0; tbl_addr = '0; tbl_data = '0;
      msix_enable = 4'b0001; msix_mask = 4'b1110;
      tick();
      chk("rst_int", 64'(msix_int), 64'(0));
      chk("rst_done", 64'(irq_done), 64'(0));
      chk("rst_err", 64'(irq_err), 64'(0));
      chk("rst_addr", msix_address, 64'(0));
      chk("rst_data", 64'(msix_data), 64'(0));
      chk("rst_fn", 64'(msix_function_number), 64'(0));
      chk("rst_tied", 64'({msix_vec_pending, msix_attr, msix_tph_present, msix_tph_type, msix_tph_st_tag}), 64'(0));
      do_reset();

      // Table-driven single-vector deliveries
      for (int r = 0; r < 4; r++) begin
         write_entry(tv[r].vec, tv[r].addr, tv[r].data);
         pulse(8'h01 << tv[r].vec);
         chk("tv_early_int", 64'(msix_int), 64'(0));
         wait_int(4, lat);
         chk("tv_issue_lat", 64'(lat + 1), 64'(tv[r].exp_lat));
         chk("tv_addr", msix_address, tv[r].addr);
         chk("tv_data", 64'(msix_data), 64'(tv[r].data));
         repeat (tv[r].dly) tick();
         chk("tv_held_addr", msix_address, tv[r].addr);
         msix_sent = 1'b1;
         tick();
         msix_sent = 1'b0;
         chk("tv_done", 64'(irq_done), 64'(tv[r].exp_done));
         chk("tv_err", 64'(irq_err), 64'(0));
         tick();
         chk("tv_done_clr", 64'(irq_done), 64'(0));
      end

      // Table write to the active vector only affects the next issue
      pulse(8'h02);
      wait_int(4, lat);
      write_entry(1, 64'h0000_0002_0000_BEE0, 32'h0000_BEEF);
      chk("hold_addr", msix_address, va(1));
      chk("hold_data", 64'(msix_data), 64'(vd(1)));
      respond(1'b1, 2);
      chk("hold_done", 64'(irq_done), 64'(8'h02));
      pulse(8'h02);
      wait_int(4, lat);
      chk("new_addr", msix_address, 64'h0000_0002_0000_BEE0);
      respond(1'b1, 1);

      // Round-robin from last grant 0: vector 7 then vector 0
      do_reset();
      pulse(8'h81);
      wait_int(4, lat);
      chk("arb_first", msix_address, va(7));
      respond(1'b1, 2);
      chk("arb_done7", 64'(irq_done), 64'(8'h80));
      wait_int(4, lat);
      chk("arb_gap", 64'(lat), 64'(1));
      chk("arb_second", msix_address, va(0));
      respond(1'b1, 2);
      chk("arb_done0", 64'(irq_done), 64'(8'h01));
      cnt = 0;
      repeat (30) begin tick(); if (msix_int) cnt++; end
      chk("arb_extra_int", 64'(cnt), 64'(0));

      // Masked vector stays pending; mask/disable during WAIT does not abort
      msix_mask = 4'b1111;
      pulse(8'h04);
      cnt = 0;
      repeat (100) begin tick(); if (msix_int) cnt++; end
      chk("mask_no_int", 64'(cnt), 64'(0));
      msix_mask = 4'b1110;
      wait_int(2, lat);
      chk("unmask_lat", 64'(lat), 64'(1));
      chk("unmask_addr", msix_address, va(2));
      msix_mask = 4'b1111; msix_enable = 4'b0000;
      respond(1'b1, 3);
      chk("mask_wait_done", 64'(irq_done), 64'(8'h04));
      msix_mask = 4'b1110; msix_enable = 4'b0001;

      // Four failures: three retries then drop
      pulse(8'h20);
      wait_int(4, lat);
      for (int a = 0; a < 4; a++) begin
         chk("fail_addr", msix_address, va(5));
         respond(1'b0, 2);
         chk("fail_no_done", 64'(irq_done | irq_err), 64'(0));
         if (a < 3) begin
            wait_int(30, lat);
            chk("retry_gap_ok", 64'(lat + 1 >= 18 && lat + 1 <= 19), 64'(1));
         end
      end
      cnt = -1;
      for (int i = 0; i < 4 && cnt < 0; i++) begin
         if (irq_err != 0) cnt = i;
         else tick();
      end
      chk("drop_seen", 64'(cnt >= 0), 64'(1));
      chk("drop_vec", 64'(irq_err), 64'(8'h20));
      cnt = 0;
      repeat (30) begin tick(); if (msix_int || irq_done != 0) cnt++; end
      chk("drop_quiet", 64'(cnt), 64'(0));

      // Timeout then successful retry
      pulse(8'h40);
      wait_int(4, lat);
      wait_int(40, lat);
      chk("timeout_retry", 64'(lat), 64'(TO + 1 + 18));
      chk("timeout_addr", msix_address, va(6));
      respond(1'b1, 1);
      chk("timeout_done", 64'(irq_done), 64'(8'h40));

      // Asynchronous reset during WAIT
      pulse(8'h02);
      wait_int(4, lat);
      tick(); tick();
      #2;
      areset = 1'b1;
      #1;
      chk("arst_addr", msix_address, 64'(0));
      chk("arst_data", 64'(msix_data), 64'(0));
      chk("arst_flags", 64'({msix_int, irq_done, irq_err}), 64'(0));
      tick();
      areset = 1'b0;
      msix_sent = 1'b1;
      tick();
      msix_sent = 1'b0;
      cnt = 0;
      repeat (30) begin tick(); if (msix_int || irq_done != 0 || irq_err != 0) cnt++; end
      chk("arst_quiet", 64'(cnt), 64'(0));

      // Randomized traffic against the behavioural model
      do_reset();
      pend = '0; req_l = '0; clr_l = '0; busy = 0; busy_l = 0; last = 0;
      sent_at = -1; done_at = -1; v = 0; dv = 0;
      for (int k = 0; k < 1500; k++) begin
         tick();
         pend_p = pend;
         pend   = (pend & ~clr_l) | req_l;
         exp_int = !busy_l && (pend_p != 0);
         chk("rnd_int", 64'(msix_int), 64'(exp_int));
         if (exp_int) begin
            v = arb(pend_p, last);
            last = v;
            chk("rnd_addr", msix_address, va(v));
            chk("rnd_data", 64'(msix_data), 64'(vd(v)));
            busy = 1;
            sent_at = cyc + int'($urandom_range(1, 6));
         end
         chk("rnd_done", 64'(irq_done), (cyc == done_at) ? 64'(8'h01 << dv) : 64'(0));
         chk("rnd_err", 64'(irq_err), 64'(0));
         busy_l = busy;
         clr_l  = '0;
         if (busy && cyc == sent_at) begin
            msix_sent = 1'b1;
            clr_l = 8'h01 << v;
            done_at = cyc + 1;
            dv = v;
            busy = 0;
         end else begin
            msix_sent = 1'b0;
         end
         req_l = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h00;
         irq_req = req_l;
      end
      irq_req = '0;
      msix_sent = 1'b0;
      repeat (5) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pcie4_cfg_msix_requester.md
# pcie4_cfg_msix_requester

User-side initiator for the PCIe4 configuration MSI-X interface. It latches per-vector interrupt requests from user logic and arbitrates among them round-robin. For each granted vector it issues an MSI-X message using the address/data held in a local vector table. It then waits for the hard block's sent/fail response, retries on failure, and reports completion or error per vector. It sits between kernel/DMA interrupt sources and the PCIe4 core's cfg MSI-X port.

## Interface
- C_NUM_VECTORS, 8: number of vectors; power of two, 2..32; IW = log2(C_NUM_VECTORS).
- C_FUNCTION, 0: PF index (0..3); selects the enable/mask bit; driven on msix_function_number.
- C_TIMEOUT, 255: cycles to wait for sent/fail before treating the attempt as failed; 1..65535.
- C_MAX_RETRY, 3: re-issues after the first failure before the request is dropped.
- aclk  in  1  sole clock.
- areset  in  1  asynchronous, active-high reset.
- irq_req  in  C_NUM_VECTORS  one-cycle pulse per vector; sets the pending bit.
- irq_done  out  C_NUM_VECTORS  one-cycle pulse: vector delivered (sent).
- irq_err  out  C_NUM_VECTORS  one-cycle pulse: vector dropped after retries exhausted.
- tbl_we  in  1  vector-table write strobe.
- tbl_idx  in  IW  table entry written.
- tbl_addr  in  64  message address.
- tbl_data  in  32  message data.
- msix_enable  in  4  per-PF MSI-X enable from core.
- msix_mask  in  4  per-PF function mask from core.
- msix_address  out  64  message address, held from issue until response.
- msix_data  out  32  message data, held likewise.
- msix_int  out  1  one-cycle issue strobe (core int_vector).
- msix_sent  in  1  core pulse: message sent.
- msix_fail  in  1  core pulse: message failed.
- msix_function_number  out  8  constant C_FUNCTION.
- msix_vec_pending  out  2  tied 0.
- msix_attr  out  3  tied 0.
- msix_tph_present  out  1  tied 0.
- msix_tph_type  out  2  tied 0.
- msix_tph_st_tag  out  8  tied 0.

## Operation
- Reset: all outputs 0 except msix_function_number = C_FUNCTION. Pending bits, table entries, retry count, timer and round-robin pointer are 0. State = IDLE.
- Pending: set by irq_req[i]; cleared on done or err for i. If irq_req[i] arrives in the same cycle as the clear, the set wins and the vector remains pending.
- Eligible: pending != 0 AND msix_enable[C_FUNCTION] AND !msix_mask[C_FUNCTION]. Masked or disabled vectors stay pending indefinitely.
- Arbitration: choose the lowest pending index at or above (last granted + 1), wrapping modulo C_NUM_VECTORS.
- States:
  - IDLE: if eligible, latch the chosen index and register its table address/data into msix_address/msix_data -> ISSUE.
  - ISSUE: msix_int = 1 for exactly this cycle; timer loaded with C_TIMEOUT -> WAIT.
  - WAIT:
    - msix_sent -> irq_done[idx], clear pending, retry = 0 -> IDLE.
    - msix_fail or timer reaching 0 -> FAILED. If sent and fail occur together, sent wins.
  - FAILED:
    - retry < C_MAX_RETRY: retry++, back off 16 cycles -> IDLE_RETRY, which re-issues the same index once eligible, bypassing arbitration.
    - otherwise: irq_err[idx], clear pending, retry = 0 -> IDLE.
- A disable or mask change during WAIT does not abort the attempt; the block still waits for a response or timeout.
- A table write to the active index does not alter the held msix_address/msix_data; it takes effect on the next issue.
- sent/fail pulses outside WAIT are ignored.

## Timing
- irq_req[i] pulsed in cycle t with the block idle and eligible: pending set at t+1, msix_int high in cycle t+2.
- msix_address/msix_data are valid from the msix_int cycle until the cycle after the response.
- msix_sent in cycle s: irq_done pulses in s+1; the next msix_int can be no earlier than s+2.
- Timeout: FAILED is entered C_TIMEOUT+1 cycles after msix_int.
- Retry: re-issue occurs at the earliest 18 cycles after the fail cycle.
- areset asserted mid-transaction: everything clears immediately; no done or err pulse is emitted.

## Configuration
- MSIX_REQ_STATS_EN defined:
  - Adds outputs stat_sent (32) and stat_fail (32), saturating counters of sent responses and failed attempts (including timeouts).
  - Adds input stat_clr, a synchronous clear that wins over a same-cycle increment.
- Not defined: these ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Write table[3] = (0x0000_0001_FEE0_0000, 0xA5); pulse irq_req[3]; sent 5 cycles after msix_int -> msix_int at t+2 carrying exactly that address/data; irq_done[3] one cycle after sent.
- Pulse irq_req = 0x81 with last grant 0 -> vector 7 issued first, then vector 0; exactly two msix_int pulses.
- Force msix_mask[0] = 1, pulse irq_req[2] -> no msix_int for 100 cycles; unmask -> issue within 2 cycles.
- Core answers fail 4 times, C_MAX_RETRY = 3 -> 4 msix_int pulses, each retry at least 18 cycles after the preceding fail; irq_err[vector] pulses after the 4th fail.
- No response, C_TIMEOUT = 10 -> retry issued 11 + 18 cycles after the first msix_int; sent on the retry -> irq_done.
- Assert areset during WAIT -> all outputs 0 asynchronously; pending cleared; no done or err pulse after release.
